// File: rtl/cordic_wrapper_pkg.sv
// Shared types for the CORDIC wrapper: function tags, result data and the
// tagged result record handed to the downstream consumer.
package cordic_wrapper_pkg;
  localparam int CORDIC_DW = 16;

  typedef enum logic [1:0] {
    F_SINCOS = 2'd0,
    F_ATAN   = 2'd1,
    F_MAG    = 2'd2,
    F_SINH   = 2'd3
  } cordic_func;

  typedef logic [CORDIC_DW-1:0] cordic_data;

  typedef struct packed {
    cordic_func func;
    cordic_data data;
  } cordic_result_t;
endpackage

// File: rtl/cordic_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is always visible on o_rdata.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module cordic_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  r_wptr, r_rptr;
  logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
  logic                         w_we, w_re;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign w_we    = i_wr & ~o_full;
  assign w_re    = i_rd & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_mem  <= '0;
    end else begin
      if (w_we) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_re) r_rptr <= r_rptr + 1'b1;
    end
  end

  a_no_overflow:  assert property (@(posedge i_clk) disable iff (!i_rst) !(i_wr && o_full));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst) !(i_rd && o_empty));
endmodule

// File: rtl/cordic_result_collector.sv
// Credit-gated issue into a non-stallable CORDIC; results are re-tagged with the
// function recorded at issue and streamed out in order with ready/valid.
module cordic_result_collector
  import cordic_wrapper_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  cordic_func                   i_req_func,
  input  logic                         i_cordic_valid,
  input  cordic_data                   i_cordic_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output cordic_func                   o_func,
  output cordic_data                   o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = $bits(cordic_func);
  localparam int RW = $bits(cordic_result_t);

  logic [CW-1:0]  r_count;
  logic           r_err;
  logic           w_fire, w_pop, w_take;
  logic           w_tag_empty, w_tag_full, w_res_empty, w_res_full;
  logic [FW-1:0]  w_tag;
  cordic_result_t w_res_in, w_res_out;

  // Ready depends only on the registered count, never on downstream i_ready.
  assign o_req_ready = (r_count < CW'(DEPTH));
  assign w_fire      = i_req_valid & o_req_ready;
  assign w_pop       = o_valid & i_ready;
  assign w_take      = i_cordic_valid & ~w_tag_empty;

  assign w_res_in.func = cordic_func'(w_tag);
  assign w_res_in.data = i_cordic_data;

  cordic_sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (w_fire),
    .i_wdata (i_req_func),
    .i_rd    (w_take),
    .o_rdata (w_tag),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  cordic_sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_res_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (w_take),
    .i_wdata (w_res_in),
    .i_rd    (w_pop),
    .o_rdata (w_res_out),
    .o_full  (w_res_full),
    .o_empty (w_res_empty)
  );

  assign o_valid = ~w_res_empty;
  assign o_func  = w_res_out.func;
  assign o_data  = w_res_out.data;
  assign o_count = r_count;
  assign o_err   = r_err;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_fire && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_fire) r_count <= r_count - 1'b1;
      // A result with no outstanding tag is an orphan (e.g. in flight across reset).
      if (i_cordic_valid && w_tag_empty) r_err <= 1'b1;
    end
  end

  a_tag_credit: assert property (@(posedge i_clk) disable iff (!i_rst) !(w_fire && w_tag_full));
  a_res_credit: assert property (@(posedge i_clk) disable iff (!i_rst) !(w_take && w_res_full));
endmodule

// File: tb/tb_cordic_result_collector.sv
// Scoreboard bench: issued requests are queued with their expected tag/data and a
// fixed-latency CORDIC model returns the data; every pop is checked in order.
module tb_cordic_result_collector;
  import cordic_wrapper_pkg::*;
  localparam int DEPTH = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  cordic_func  i_req_func = F_SINCOS;
  logic        i_cordic_valid = 1'b0;
  cordic_data  i_cordic_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  cordic_func  o_func;
  cordic_data  o_data;
  logic [3:0]  o_count;
  logic        o_err;

  cordic_result_collector #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_func(i_req_func),
    .i_cordic_valid(i_cordic_valid), .i_cordic_data(i_cordic_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_func(o_func), .o_data(o_data),
    .o_count(o_count), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int due; cordic_data d; } sched_t;
  sched_t         sched[$];
  cordic_result_t expq[$];
  int total = 0, bad = 0, cyc = 0, lat = 12, mcnt = 0;
  cordic_data next_data = '0;
  bit force_orphan = 0;

  // One clock: check any pop against the scoreboard, log any fire, then drive the
  // CORDIC model output for the next cycle.
  task automatic tick();
    bit f, p;
    cordic_result_t e;
    sched_t s;
    f = i_rst && i_req_valid && o_req_ready;
    p = i_rst && o_valid && i_ready;
    if (p) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got func=%0d data=%h, scoreboard empty", o_func, o_data);
      end else begin
        e = expq.pop_front();
        if (o_func !== e.func || o_data !== e.data) begin
          bad++;
          $display("FAIL pop_order: got func=%0d data=%h, want func=%0d data=%h",
                   o_func, o_data, e.func, e.data);
        end
      end
      mcnt--;
    end
    if (f) begin
      e.func = i_req_func; e.data = next_data; expq.push_back(e);
      s.due = cyc + lat; s.d = next_data; sched.push_back(s);
      mcnt++;
    end
    @(posedge i_clk); #1;
    cyc++;
    i_cordic_valid = force_orphan;
    i_cordic_data  = 16'hdead;
    if (sched.size() > 0 && sched[0].due == cyc) begin
      s = sched.pop_front();
      i_cordic_valid = 1'b1;
      i_cordic_data  = s.d;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b0; i_req_valid = 0; i_ready = 0; i_cordic_valid = 0;
    sched.delete(); expq.delete(); mcnt = 0;
    @(posedge i_clk); #1;
    cyc++;
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (o_valid !== 0 || o_req_ready !== 1 || o_count !== 0 || o_err !== 0 || o_data !== '0 || o_func !== F_SINCOS) begin
      bad++;
      $display("FAIL reset_state: valid=%b rdy=%b cnt=%0d err=%b data=%h func=%0d, want 0 1 0 0 0000 0",
               o_valid, o_req_ready, o_count, o_err, o_data, o_func);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
  endtask

  task automatic test_single();
    int c0, n;
    lat = 14;
    i_req_func = F_ATAN; next_data = 16'h0001; i_req_valid = 1;
    c0 = cyc;
    tick();
    i_req_valid = 0;
    n = 0;
    while (!o_valid && n < 40) begin tick(); n++; end
    total++;
    if (cyc - c0 != 15) begin
      bad++;
      $display("FAIL single_latency: o_valid at cycle %0d, want 15", cyc - c0);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (o_valid !== 1 || o_func !== F_ATAN || o_data !== 16'h0001) begin
        bad++;
        $display("FAIL single_hold: valid=%b func=%0d data=%h, want 1 %0d 0001", o_valid, o_func, o_data, F_ATAN);
      end
      tick();
    end
    i_ready = 1; tick(); i_ready = 0;
    total++;
    if (o_count !== 0 || o_valid !== 0) begin
      bad++;
      $display("FAIL single_drain: cnt=%0d valid=%b, want 0 0", o_count, o_valid);
    end
  endtask

  task automatic test_fill();
    int n;
    lat = 12; i_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      i_req_func = (i % 2) ? F_MAG : F_ATAN;
      next_data = cordic_data'(i);
      i_req_valid = 1;
      tick();
    end
    i_req_valid = 0;
    total++;
    if (o_count !== 4'd8 || o_req_ready !== 0) begin
      bad++;
      $display("FAIL fill_full: cnt=%0d rdy=%b, want 8 0", o_count, o_req_ready);
    end
    n = 0;
    while (sched.size() > 0 && n < 40) begin tick(); n++; end
    tick();
    total++;
    if (o_valid !== 1 || o_count !== 4'd8 || o_req_ready !== 0) begin
      bad++;
      $display("FAIL fill_landed: valid=%b cnt=%0d rdy=%b, want 1 8 0", o_valid, o_count, o_req_ready);
    end
    i_ready = 1; tick(); i_ready = 0;
    total++;
    if (o_req_ready !== 1 || o_count !== 4'd7) begin
      bad++;
      $display("FAIL pop_from_full: rdy=%b cnt=%0d, want 1 7", o_req_ready, o_count);
    end
    i_req_func = F_SINH; next_data = 16'h0008; i_req_valid = 1; i_ready = 1;
    tick();
    i_req_valid = 0; i_ready = 0;
    total++;
    if (o_count !== 4'd7) begin
      bad++;
      $display("FAIL fire_and_pop: cnt=%0d, want 7", o_count);
    end
    i_ready = 1;
    n = 0;
    while (expq.size() > 0 && n < 80) begin tick(); n++; end
    i_ready = 0;
    total++;
    if (expq.size() != 0 || o_count !== 0 || o_valid !== 0) begin
      bad++;
      $display("FAIL fill_drain: left=%0d cnt=%0d valid=%b, want 0 0 0", expq.size(), o_count, o_valid);
    end
  endtask

  task automatic test_orphan();
    int n;
    force_orphan = 1; tick(); force_orphan = 0; tick();
    total++;
    if (o_err !== 1 || o_valid !== 0 || o_count !== 0) begin
      bad++;
      $display("FAIL orphan_flag: err=%b valid=%b cnt=%0d, want 1 0 0", o_err, o_valid, o_count);
    end
    lat = 12;
    i_req_func = F_SINH; next_data = 16'h55aa; i_req_valid = 1;
    tick();
    i_req_valid = 0;
    n = 0;
    while (!o_valid && n < 40) begin tick(); n++; end
    i_ready = 1; tick(); i_ready = 0;
    total++;
    if (expq.size() != 0 || o_count !== 0 || o_err !== 1) begin
      bad++;
      $display("FAIL orphan_after: left=%0d cnt=%0d err=%b, want 0 0 1", expq.size(), o_count, o_err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 12;
    for (int i = 0; i < 3; i++) begin
      i_req_func = F_MAG; next_data = cordic_data'(16'h0100 + i); i_req_valid = 1; tick();
    end
    i_req_valid = 0;
    n = 0;
    while (!o_valid && n < 40) begin tick(); n++; end
    i_rst = 1'b0;
    #1;
    total++;
    if (o_valid !== 0 || o_req_ready !== 1 || o_count !== 0 || o_err !== 0 || o_data !== '0) begin
      bad++;
      $display("FAIL reset_async: valid=%b rdy=%b cnt=%0d err=%b data=%h, want 0 1 0 0 0000",
               o_valid, o_req_ready, o_count, o_err, o_data);
    end
    do_reset();
    repeat (lat + 2) tick();
    total++;
    if (o_err !== 0 || o_valid !== 0) begin
      bad++;
      $display("FAIL reset_quiet: err=%b valid=%b, want 0 0", o_err, o_valid);
    end
  endtask

  task automatic test_stress();
    int issued, n;
    lat = 12; issued = 0; n = 0;
    while ((issued < 1000 || expq.size() > 0) && n < 30000) begin
      i_req_valid = (issued < 1000) && ($urandom_range(0, 3) != 0);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_req_func  = cordic_func'($urandom_range(0, 3));
      next_data   = cordic_data'($urandom);
      if (i_req_valid && o_req_ready) issued++;
      tick();
      n++;
      total++;
      if (o_count !== 4'(mcnt) || o_req_ready !== (mcnt < DEPTH)) begin
        bad++;
        $display("FAIL stress_count: cnt=%0d rdy=%b, want %0d %b", o_count, o_req_ready, mcnt, mcnt < DEPTH);
      end
    end
    i_req_valid = 0; i_ready = 0;
    total++;
    if (n >= 30000 || o_err !== 0 || o_valid !== 0) begin
      bad++;
      $display("FAIL stress_end: cycles=%0d left=%0d err=%b valid=%b, want done 0 0 0", n, expq.size(), o_err, o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_orphan();
    test_reset_mid();
    test_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
